ps2_key_event_sequencer: RTL and testbench
==========================================

// Module: ps2_key_event_sequencer
// PURPOSE
//  Sits after the PS/2 byte receiver. Parses its byte stream (E0/F0 prefixes, E1 pause sequence).
//  Maps the six Tetris keys to action events and queues them in a small FIFO with a valid/ready handshake.
//  Keeps a held-key mask for game logic. Recovers from broken multi-byte sequences with an inter-byte timeout.
// PARAMETERS
//  FIFO_DEPTH      4        event queue entries (power of 2, >=2)
//  TIMEOUT_CYCLES  250000   CLOCK_50 cycles without a byte before a partial sequence is abandoned (5 ms)
//  REPEAT_EN       0        1: typematic repeat makes of a held key are queued; 0: suppressed
// PORTS
//  CLOCK_50          in   1  system clock, all logic on rising edge
//  reset             in   1  synchronous, active-high
//  received_data     in   8  byte from PS/2 receiver
//  received_data_en  in   1  1-cycle strobe: received_data valid
//  ev_valid          out  1  FIFO head holds an event
//  ev_ready          in   1  consumer accepts head when ev_valid&&ev_ready
//  ev_code           out  3  action: 0 LEFT,1 RIGHT,2 ROTATE,3 SOFT_DROP,4 HARD_DROP,5 PAUSE
//  ev_make           out  1  1 = press, 0 = release
//  held_keys         out  6  bit[i] = action i currently held
//  overflow          out  1  sticky: an event was dropped because the FIFO was full
//  seq_error         out  1  1-cycle pulse: timeout abandoned a partial sequence
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM in IDLE, timeout counter 0. A mid-sequence reset discards the partial sequence.
//  Key map: E0 6B LEFT, E0 74 RIGHT, E0 75 ROTATE, E0 72 SOFT_DROP, 29 HARD_DROP, 4D PAUSE.
//   Any other byte completes a sequence with no event.
//  FSM, advanced only on received_data_en:
//   IDLE: E0->EXT; F0->BRK; E1->SKIP (cnt=7); AA/FA/FE/EE/00/FF ignored (stay IDLE); else final byte, make.
//   EXT: F0->EXT_BRK; else final byte, extended make, ->IDLE.
//   BRK: final byte, break, ->IDLE. EXT_BRK: final byte, extended break, ->IDLE.
//   SKIP: consume 7 further bytes, no events, ->IDLE.
//  Final byte is decoded on the same edge it is sampled.
//   Mapped make: held_keys[i]<=1; event {i,1} pushed, unless REPEAT_EN=0 and held_keys[i] was already 1.
//   Mapped break: held_keys[i]<=0; event {i,0} pushed, even if the bit was already 0.
//  Latency: event visible on ev_valid/ev_code the cycle after the final strobe if the FIFO was empty.
//   FIFO is show-ahead: ev_code/ev_make reflect the head whenever ev_valid=1 and hold until popped.
//  Timeout: counter clears on every strobe and counts while FSM != IDLE.
//   At TIMEOUT_CYCLES-1: ->IDLE, seq_error pulses 1 cycle, no event.
//  FIFO: push and pop in the same cycle are both honoured at any occupancy, count unchanged.
//   Full and pop in the same cycle: push accepted. Full and no pop: push dropped, overflow<=1 (cleared only by reset).
//   Pop when empty is a no-op. Pointers wrap modulo FIFO_DEPTH, count width clog2(FIFO_DEPTH)+1.
//  received_data_en is assumed 1-cycle. Back-to-back strobes on consecutive cycles must be handled.
// TESTING
//  T1 bytes 29 ; F0 29, ev_ready=1 -> events {4,1} then {4,0}; held_keys[4] 0->1->0; first ev_valid 1 cycle after strobe.
//  T2 bytes E0 6B ; E0 F0 6B -> {0,1},{0,0}. Bytes E0 1C (unmapped) -> no event, FSM IDLE.
//  T3 REPEAT_EN=0, bytes 29 29 29 -> one {4,1}. Rerun with REPEAT_EN=1 -> three {4,1}.
//  T4 ev_ready=0, 5 distinct makes, FIFO_DEPTH=4 -> first 4 queued in order, overflow=1.
//   Then pop while pushing when full -> no drop, order preserved.
//  T5 byte E0 then idle TIMEOUT_CYCLES -> seq_error pulse, IDLE. Following byte 74 -> no event (not treated as RIGHT).
//  T6 E1 14 77 E1 F0 14 F0 77 then 29 -> only {4,1}. Reset asserted after E0 -> next 6B yields no event.

Source files
------------

// File: rtl/ps2_key_event_sequencer.sv
// ps2_key_event_sequencer: parse PS/2 scan bytes into Tetris action events queued behind a valid/ready FIFO
//  CLOCK_50, reset               clock, synchronous active-high reset
//  received_data[7:0], _en       byte and 1-cycle strobe from the PS/2 receiver
//  ev_valid/ev_ready/ev_code/ev_make   show-ahead event queue head and handshake
//  held_keys[5:0], overflow, seq_error held-key mask, sticky drop flag, timeout pulse
module ps2_key_event_sequencer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 250000,
  parameter bit REPEAT_EN      = 1'b0
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [2:0] ev_code,
  output logic       ev_make,
  output logic [5:0] held_keys,
  output logic       overflow,
  output logic       seq_error
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;
  state_t state;
  logic [TW-1:0] tcnt;
  logic [2:0] skip_cnt;
  logic [3:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0] d;
  logic ignore, fin, ext, brk, hit, push, pop, full, wr_en, timeout;
  logic [2:0] idx;
  always_comb begin
    d = received_data;
    ignore = d == 8'hAA || d == 8'hFA || d == 8'hFE || d == 8'hEE || d == 8'h00 || d == 8'hFF;
    ext = state == EXT || state == EXT_BRK;
    brk = state == BRK || state == EXT_BRK;
    // a byte is final when it does not extend the current sequence
    fin = received_data_en && (state == EXT ? d != 8'hF0 :
          brk ? 1'b1 :
          state == IDLE ? !(d == 8'hE0 || d == 8'hF0 || d == 8'hE1 || ignore) : 1'b0);
    {hit, idx} = ext ? (d == 8'h6B ? {1'b1, 3'd0} : d == 8'h74 ? {1'b1, 3'd1} :
                        d == 8'h75 ? {1'b1, 3'd2} : d == 8'h72 ? {1'b1, 3'd3} : 4'd0)
                     : (d == 8'h29 ? {1'b1, 3'd4} : d == 8'h4D ? {1'b1, 3'd5} : 4'd0);
    // typematic repeats of an already-held key are suppressed unless REPEAT_EN
    push = fin && hit && (brk || REPEAT_EN || !held_keys[idx]);
    pop = ev_valid && ev_ready;
    full = count == CW'(FIFO_DEPTH);
    wr_en = push && (!full || pop);
    timeout = !received_data_en && state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1);
  end
  assign ev_valid = count != '0;
  assign ev_code = mem[rd_ptr][3:1];
  assign ev_make = mem[rd_ptr][0];
  always_ff @(posedge CLOCK_50)
    if (wr_en) mem[wr_ptr] <= {idx, !brk};
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      tcnt <= '0;
      skip_cnt <= '0;
      held_keys <= '0;
      overflow <= 1'b0;
      seq_error <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      seq_error <= timeout;
      tcnt <= (received_data_en || timeout || state == IDLE) ? '0 : tcnt + TW'(1);
      if (timeout) state <= IDLE;
      else if (received_data_en)
        case (state)
          IDLE: begin
            state <= d == 8'hE0 ? EXT : d == 8'hF0 ? BRK : d == 8'hE1 ? SKIP : IDLE;
            skip_cnt <= 3'd7;
          end
          EXT: state <= d == 8'hF0 ? EXT_BRK : IDLE;
          SKIP: begin
            state <= skip_cnt == 3'd1 ? IDLE : SKIP;
            skip_cnt <= skip_cnt - 3'd1;
          end
          default: state <= IDLE;
        endcase
      if (fin && hit) held_keys[idx] <= !brk;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(pop);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ps2_key_event_sequencer.sv
// tb_ps2_key_event_sequencer: table-driven and directed checks of the PS/2 key event sequencer
module tb_ps2_key_event_sequencer;
  localparam int TO = 40;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, rdy = 1'b0;
  logic [7:0] data = '0;
  logic v0, m0, o0, s0, v1, m1, o1, s1;
  logic [2:0] c0, c1;
  logic [5:0] h0, h1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ps2_key_event_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO), .REPEAT_EN(1'b0)) dut0 (
    .CLOCK_50(clk), .reset(rst), .received_data(data), .received_data_en(en),
    .ev_valid(v0), .ev_ready(rdy), .ev_code(c0), .ev_make(m0),
    .held_keys(h0), .overflow(o0), .seq_error(s0));
  ps2_key_event_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO), .REPEAT_EN(1'b1)) dut1 (
    .CLOCK_50(clk), .reset(rst), .received_data(data), .received_data_en(en),
    .ev_valid(v1), .ev_ready(rdy), .ev_code(c1), .ev_make(m1),
    .held_keys(h1), .overflow(o1), .seq_error(s1));
  typedef struct {
    logic [7:0] b [3];
    int n;
    bit ev;
    logic [2:0] code;
    bit make;
    logic [5:0] held;
  } vec_t;
  vec_t tv [15];
  task automatic set_vec(input int i, input logic [7:0] b0, b1, b2, input int n, input bit ev,
                         input logic [2:0] code, input bit make, input logic [5:0] held);
    tv[i].b[0] = b0; tv[i].b[1] = b1; tv[i].b[2] = b2;
    tv[i].n = n; tv[i].ev = ev; tv[i].code = code; tv[i].make = make; tv[i].held = held;
  endtask
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data = b;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rdy = 1'b0;
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic pop_exp(input string name, input int code, input int make);
    chk({name, "_valid"}, int'(v0), 1);
    chk({name, "_code"}, int'(c0), code);
    chk({name, "_make"}, int'(m0), make);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask
  initial begin
    int n0, n1, pulses;
    set_vec(0,  8'h29, 8'h00, 8'h00, 1, 1, 3'd4, 1, 6'b010000);
    set_vec(1,  8'hF0, 8'h29, 8'h00, 2, 1, 3'd4, 0, 6'b000000);
    set_vec(2,  8'hE0, 8'h6B, 8'h00, 2, 1, 3'd0, 1, 6'b000001);
    set_vec(3,  8'hE0, 8'hF0, 8'h6B, 3, 1, 3'd0, 0, 6'b000000);
    set_vec(4,  8'hE0, 8'h1C, 8'h00, 2, 0, 3'd0, 0, 6'b000000);
    set_vec(5,  8'hE0, 8'h74, 8'h00, 2, 1, 3'd1, 1, 6'b000010);
    set_vec(6,  8'hE0, 8'h75, 8'h00, 2, 1, 3'd2, 1, 6'b000110);
    set_vec(7,  8'hE0, 8'h72, 8'h00, 2, 1, 3'd3, 1, 6'b001110);
    set_vec(8,  8'h4D, 8'h00, 8'h00, 1, 1, 3'd5, 1, 6'b101110);
    set_vec(9,  8'hF0, 8'h4D, 8'h00, 2, 1, 3'd5, 0, 6'b001110);
    set_vec(10, 8'hE0, 8'hF0, 8'h74, 3, 1, 3'd1, 0, 6'b001100);
    set_vec(11, 8'hAA, 8'h00, 8'h00, 1, 0, 3'd0, 0, 6'b001100);
    set_vec(12, 8'hF0, 8'h29, 8'h00, 2, 1, 3'd4, 0, 6'b001100);
    set_vec(13, 8'hE0, 8'h29, 8'h00, 2, 0, 3'd0, 0, 6'b001100);
    set_vec(14, 8'hF0, 8'h6B, 8'h00, 2, 0, 3'd0, 0, 6'b001100);
    do_reset();
    chk("rst_valid", int'(v0), 0);
    chk("rst_held", int'(h0), 0);
    chk("rst_overflow", int'(o0), 0);
    chk("rst_seq_error", int'(s0), 0);
    @(negedge clk);
    data = 8'h29;
    en = 1'b1;
    chk("lat_before_edge", int'(v0), 0);
    @(posedge clk);
    #1;
    chk("lat_after_edge", int'(v0), 1);
    en = 1'b0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      for (int j = 0; j < tv[i].n; j++) send(tv[i].b[j]);
      chk($sformatf("vec%0d_valid", i), int'(v0), int'(tv[i].ev));
      if (tv[i].ev) pop_exp($sformatf("vec%0d", i), int'(tv[i].code), int'(tv[i].make));
      chk($sformatf("vec%0d_empty", i), int'(v0), 0);
      chk($sformatf("vec%0d_held", i), int'(h0), int'(tv[i].held));
    end
    do_reset();
    send(8'h29); send(8'h29); send(8'h29);
    n0 = 0; n1 = 0;
    @(negedge clk);
    rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n0 += int'(v0);
      n1 += int'(v1);
      @(negedge clk);
    end
    rdy = 1'b0;
    chk("repeat_off_events", n0, 1);
    chk("repeat_on_events", n1, 3);
    do_reset();
    send(8'h29);
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74);
    send(8'hE0); send(8'h75);
    chk("full_no_overflow", int'(o0), 0);
    @(negedge clk);
    data = 8'h4D;
    en = 1'b1;
    rdy = 1'b1;
    @(negedge clk);
    en = 1'b0;
    rdy = 1'b0;
    chk("push_pop_full_no_overflow", int'(o0), 0);
    send(8'hE0); send(8'h72);
    chk("overflow_set", int'(o0), 1);
    pop_exp("ord0", 0, 1);
    pop_exp("ord1", 1, 1);
    pop_exp("ord2", 2, 1);
    pop_exp("ord3", 5, 1);
    chk("drained", int'(v0), 0);
    chk("overflow_sticky", int'(o0), 1);
    do_reset();
    chk("overflow_reset", int'(o0), 0);
    send(8'hE0);
    pulses = 0;
    for (int i = 0; i < 3 * TO; i++) begin
      @(negedge clk);
      pulses += int'(s0);
    end
    chk("timeout_pulses", pulses, 1);
    send(8'h74);
    chk("timeout_then_74_valid", int'(v0), 0);
    chk("timeout_then_74_held", int'(h0), 0);
    send(8'hE0);
    pulses = 0;
    for (int i = 0; i < TO - 5; i++) begin
      @(negedge clk);
      pulses += int'(s0);
    end
    send(8'h74);
    chk("near_timeout_pulses", pulses + int'(s0), 0);
    pop_exp("near_timeout_right", 1, 1);
    do_reset();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause_seq_no_event", int'(v0), 0);
    send(8'h29);
    pop_exp("after_pause_seq", 4, 1);
    chk("after_pause_seq_empty", int'(v0), 0);
    do_reset();
    send(8'hE0);
    do_reset();
    send(8'h6B);
    chk("mid_reset_valid", int'(v0), 0);
    chk("mid_reset_held", int'(h0), 0);
    @(negedge clk);
    data = 8'hE0;
    en = 1'b1;
    @(negedge clk);
    data = 8'h74;
    @(negedge clk);
    en = 1'b0;
    pop_exp("b2b", 1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
